// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//   Microcode sequencer of the BasicCPU. It is the only master of the shared
//   8-bit bus: it walks the fetch (T0,T1) and execute (T2..T4) T-states and
//   drives the active-low read/write/inc strobes of PC, MAR, RAM, IR, A, B,
//   ALU and OUT. It holds no datapath; the bus never enters this block.
//
//   Ports
//     i_clk, i_reset        clock (posedge), async active-high reset
//     i_ir[7:0]             instruction register, opcode = i_ir[7:4]
//     i_carry, i_zero       flags, used in T2 of JC / JZ
//     o_*_read_n/_write_n   active-low bus strobes
//     o_pc_inc_n            PC increment strobe (active low)
//     o_alu_sub             ALU subtract select (active high)
//     o_tstate[2:0]         current T-index 0..4, 7 in IDLE/HALT
//     o_halted              high while halted
//
//   Optional build macro SEQ_SINGLE_STEP_EN adds i_run and i_step:
//     i_run=1 free-runs; i_run=0 executes one T-state per i_step rising edge
//     (i_step is an asynchronous button, synchronised here).
// -----------------------------------------------------------------------------
module control_sequencer #(
    parameter int MAX_T = 5
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_ir,
    input  logic       i_carry,
    input  logic       i_zero,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic       i_run,
    input  logic       i_step,
`endif
    output logic       o_pc_read_n,
    output logic       o_pc_write_n,
    output logic       o_pc_inc_n,
    output logic       o_mar_write_n,
    output logic       o_ram_read_n,
    output logic       o_ram_write_n,
    output logic       o_ir_read_n,
    output logic       o_ir_write_n,
    output logic       o_a_read_n,
    output logic       o_a_write_n,
    output logic       o_b_write_n,
    output logic       o_alu_read_n,
    output logic       o_alu_sub,
    output logic       o_out_write_n,
    output logic [2:0] o_tstate,
    output logic       o_halted
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] opcode_s;
    logic       advance_s;
    // Operand nibble belongs to the datapath; it is deliberately not decoded.
    logic       ir_operand_unused_s;

    assign opcode_s            = i_ir[7:4];
    assign ir_operand_unused_s = ^i_ir[3:0];

`ifdef SEQ_SINGLE_STEP_EN
    logic [1:0] step_sync_q;
    logic       step_prev_q;
    logic       step_rise_s;

    // Two-flop synchroniser for the step button plus a delayed copy for edge detect.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            step_sync_q <= 2'b00;
            step_prev_q <= 1'b0;
        end else begin
            step_sync_q <= {step_sync_q[0], i_step};
            step_prev_q <= step_sync_q[1];
        end
    end

    assign step_rise_s = step_sync_q[1] & ~step_prev_q;
    assign advance_s   = i_run | step_rise_s;
`else
    assign advance_s   = 1'b1;
`endif

    // Next T-state: each opcode returns to T0 right after its last step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2: begin
                case (opcode_s)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: state_d = S_T3;
                    OP_HLT:                         state_d = S_HALT;
                    default:                        state_d = S_T0;
                endcase
            end
            S_T3: begin
                if ((opcode_s == OP_ADD) || (opcode_s == OP_SUB)) begin
                    state_d = S_T4;
                end else begin
                    state_d = S_T0;
                end
            end
            S_T4:   state_d = S_T0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // State register; when stepping, a T-state only completes on an advance.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
        end else if (advance_s) begin
            state_q <= state_d;
        end else begin
            state_q <= state_q;
        end
    end

    // Active-high strobe set: {pc_rd, pc_wr, pc_inc, mar_wr, ram_rd, ram_wr,
    // ir_rd, ir_wr, a_rd, a_wr, b_wr, alu_rd, out_wr}.
    logic [12:0] strb_s;
    logic        sub_s;

    // Microcode decode of the registered state, the opcode and the flags.
    always_comb begin
        strb_s = 13'd0;
        sub_s  = 1'b0;
        case (state_q)
            S_T0: strb_s = 13'b1_0_0_1_0_0_0_0_0_0_0_0_0;
            S_T1: strb_s = 13'b0_0_1_0_1_0_0_1_0_0_0_0_0;
            S_T2: begin
                case (opcode_s)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA:
                            strb_s = 13'b0_0_0_1_0_0_1_0_0_0_0_0_0;
                    OP_LDI: strb_s = 13'b0_0_0_0_0_0_1_0_0_1_0_0_0;
                    OP_JMP: strb_s = 13'b0_1_0_0_0_0_1_0_0_0_0_0_0;
                    OP_JC:  strb_s = i_carry ? 13'b0_1_0_0_0_0_1_0_0_0_0_0_0 : 13'd0;
                    OP_JZ:  strb_s = i_zero  ? 13'b0_1_0_0_0_0_1_0_0_0_0_0_0 : 13'd0;
                    OP_OUT: strb_s = 13'b0_0_0_0_0_0_0_0_1_0_0_0_1;
                    default: strb_s = 13'd0;
                endcase
            end
            S_T3: begin
                case (opcode_s)
                    OP_LDA: strb_s = 13'b0_0_0_0_1_0_0_0_0_1_0_0_0;
                    OP_ADD: strb_s = 13'b0_0_0_0_1_0_0_0_0_0_1_0_0;
                    OP_SUB: begin
                        strb_s = 13'b0_0_0_0_1_0_0_0_0_0_1_0_0;
                        sub_s  = 1'b1;
                    end
                    OP_STA: strb_s = 13'b0_0_0_0_0_1_0_0_1_0_0_0_0;
                    default: strb_s = 13'd0;
                endcase
            end
            S_T4: begin
                if ((opcode_s == OP_ADD) || (opcode_s == OP_SUB)) begin
                    strb_s = 13'b0_0_0_0_0_0_0_0_0_1_0_1_0;
                    sub_s  = (opcode_s == OP_SUB);
                end else begin
                    strb_s = 13'd0;
                end
            end
            default: strb_s = 13'd0;
        endcase
        // A waiting (not advancing) T-state must not disturb the datapath.
        if (!advance_s) begin
            strb_s = 13'd0;
            sub_s  = 1'b0;
        end else begin
            strb_s = strb_s;
            sub_s  = sub_s;
        end
    end

    assign {o_pc_read_n, o_pc_write_n, o_pc_inc_n, o_mar_write_n,
            o_ram_read_n, o_ram_write_n, o_ir_read_n, o_ir_write_n,
            o_a_read_n, o_a_write_n, o_b_write_n, o_alu_read_n,
            o_out_write_n} = ~strb_s;
    assign o_alu_sub = sub_s;
    assign o_halted  = (state_q == S_HALT);

    // T-index straight from the state register; 7 marks IDLE/HALT.
    always_comb begin
        case (state_q)
            S_T0:    o_tstate = 3'd0;
            S_T1:    o_tstate = 3'd1;
            S_T2:    o_tstate = 3'd2;
            S_T3:    o_tstate = 3'd3;
            S_T4:    o_tstate = (MAX_T > 4) ? 3'd4 : 3'd7;
            default: o_tstate = 3'd7;
        endcase
    end

endmodule
